// File: rtl/isa_bus_pkg.sv
// Shared types and constants for the ISA I/O cycle engine.
package isa_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_STROBE   = 3'd2,
      ST_WAIT_RDY = 3'd3,
      ST_HOLD     = 3'd4,
      ST_RECOVER  = 3'd5
   } isa_state_e;

   localparam int DEF_ADDR_W          = 16;
   localparam int DEF_DATA_W          = 8;
   localparam int DEF_SETUP_CYCLES    = 1;
   localparam int DEF_STROBE_CYCLES   = 4;
   localparam int DEF_RECOVERY_CYCLES = 2;
   localparam int DEF_READY_TIMEOUT   = 64;

   // Phase timer width; comfortably covers any realistic bus timing.
   localparam int TIMER_W = 16;

   function automatic bit data_w_legal(input int w);
      return (w == 8) || (w == 16);
   endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and RECOVER phases.
// Loading N-1 makes done assert on the Nth cycle after the load edge.
module isa_cycle_timer
   import isa_bus_pkg::*;
#(
   parameter int W = TIMER_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // Count down to zero and park there until the next load.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/isa_io_cycle_engine.sv
// ISA I/O bus-cycle sequencer with programmable setup/strobe/recovery timing,
// IOCHRDY wait-state extension with timeout, and 8/16-bit data.
//
// state       | meaning
// ------------+----------------------------------------------------------
// IDLE        | req_ready high, waiting for a host request
// SETUP       | address (and write data) driven, strobes still high
// STROBE      | IOR#/IOW# low for the programmed minimum width
// WAIT_RDY    | strobe held low while the card pulls IOCHRDY low
// HOLD        | strobe released, bus still driven, response published
// RECOVER     | bus released, idle gap before the next accept
module isa_io_cycle_engine
   import isa_bus_pkg::*;
#(
   parameter int ADDR_W          = DEF_ADDR_W,
   parameter int DATA_W          = DEF_DATA_W,
   parameter int SETUP_CYCLES    = DEF_SETUP_CYCLES,
   parameter int STROBE_CYCLES   = DEF_STROBE_CYCLES,
   parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES,
   parameter int READY_TIMEOUT   = DEF_READY_TIMEOUT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] isa_addr,
   output logic              isa_addr_oe,
   output logic [DATA_W-1:0] isa_data_out,
   output logic              isa_data_oe,
   input  logic [DATA_W-1:0] isa_data_in,
   output logic              isa_ior_n,
   output logic              isa_iow_n,
   input  logic              isa_iochrdy,
   output logic [2:0]        state_debug
);

   if (!data_w_legal(DATA_W)) begin : g_bad_data_w
      $error("isa_io_cycle_engine: DATA_W must be 8 or 16");
   end

   localparam int WAIT_W = $clog2(READY_TIMEOUT) + 1;
   localparam logic [WAIT_W-1:0]  WAIT_LAST    = WAIT_W'(READY_TIMEOUT - 1);
   localparam logic [TIMER_W-1:0] SETUP_LOAD   = TIMER_W'(SETUP_CYCLES - 1);
   localparam logic [TIMER_W-1:0] STROBE_LOAD  = TIMER_W'(STROBE_CYCLES - 1);
   localparam logic [TIMER_W-1:0] RECOVER_LOAD = TIMER_W'(RECOVERY_CYCLES - 1);

   isa_state_e          state;
   logic                write_q;
   logic                tmo_q;
   logic [DATA_W-1:0]   data_cap;
   logic [WAIT_W-1:0]   wait_cnt;
   logic                tmr_load;
   logic [TIMER_W-1:0]  tmr_val;
   logic                tmr_done;

   isa_cycle_timer #(.W(TIMER_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (tmr_done)
   );

   // Timer reload on entry to each timed phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE:  if (req_valid) begin tmr_load = 1'b1; tmr_val = SETUP_LOAD; end
         ST_SETUP: if (tmr_done)  begin tmr_load = 1'b1; tmr_val = STROBE_LOAD; end
         ST_HOLD:  begin tmr_load = 1'b1; tmr_val = RECOVER_LOAD; end
         default:  ;
      endcase
   end

   // Bus-cycle sequencer; every pad and response output is a register here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         req_ready    <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_timeout  <= 1'b0;
         isa_addr     <= '0;
         isa_addr_oe  <= 1'b0;
         isa_data_out <= '0;
         isa_data_oe  <= 1'b0;
         isa_ior_n    <= 1'b1;
         isa_iow_n    <= 1'b1;
         write_q      <= 1'b0;
         tmo_q        <= 1'b0;
         data_cap     <= '0;
         wait_cnt     <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  isa_addr     <= req_addr;
                  isa_data_out <= req_wdata;
                  write_q      <= req_write;
                  isa_addr_oe  <= 1'b1;
                  isa_data_oe  <= req_write;
                  req_ready    <= 1'b0;
                  tmo_q        <= 1'b0;
                  rsp_timeout  <= 1'b0;
                  state        <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (tmr_done) begin
                  isa_ior_n <= write_q;
                  isa_iow_n <= ~write_q;
                  state     <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               if (tmr_done) begin
                  if (isa_iochrdy) begin
                     isa_ior_n <= 1'b1;
                     isa_iow_n <= 1'b1;
                     if (!write_q) data_cap <= isa_data_in;
                     state <= ST_HOLD;
                  end else begin
                     wait_cnt <= '0;
                     state    <= ST_WAIT_RDY;
                  end
               end
            end
            ST_WAIT_RDY: begin
               if (isa_iochrdy) begin
                  isa_ior_n <= 1'b1;
                  isa_iow_n <= 1'b1;
                  if (!write_q) data_cap <= isa_data_in;
                  state <= ST_HOLD;
               end else if (wait_cnt == WAIT_LAST) begin
                  // Card never released the channel: finish the cycle with a flag.
                  isa_ior_n <= 1'b1;
                  isa_iow_n <= 1'b1;
                  tmo_q     <= 1'b1;
                  if (!write_q) data_cap <= '1;
                  state <= ST_HOLD;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ST_HOLD: begin
               rsp_valid   <= 1'b1;
               rsp_timeout <= tmo_q;
               if (!write_q) rsp_rdata <= data_cap;
               isa_addr_oe <= 1'b0;
               isa_data_oe <= 1'b0;
               state       <= ST_RECOVER;
            end
            ST_RECOVER: begin
               if (tmr_done) begin
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               isa_ior_n <= 1'b1;
               isa_iow_n <= 1'b1;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign state_debug = state;

endmodule
